// File: rtl/alu_exec_pipe.sv
// ---------------------------------------------------------------------------
// alu_exec_pipe
//
// Purpose
//   Executes the 4-bit ALU control code coming out of the ALU control decoder
//   on two DW-bit operands: add/sub, signed set-less-than, or/and/nor, and
//   the six branch tests. It is a two-stage pipeline:
//     S1 : registers op / a / b on an input handshake.
//     S2 : registers the computed result and flags and presents them
//          on out_*.
//   Each stage has a valid/ready handshake. Throughput is one op per cycle
//   while out_ready stays high.
//
// Handshake semantics (both sides)
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A producer holding valid high may not be withdrawn by the consumer.
//   The DUT keeps out_* stable while out_valid && !out_ready.
//   in_ready is a combinational function of the pipeline registers and
//   out_ready only. It never depends on in_valid.
//
// Parameters
//   DW     operand/result width (>= 8)
//   CNT_W  width of the taken-branch counter
//
// Configuration macro
//   ALU_TAKEN_CNT_EN  when defined, taken_cnt counts output handshakes that
//                     carry out_taken=1. The count saturates at all-ones and
//                     is cleared only by reset. When undefined, taken_cnt is
//                     tied to 0.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      op/operands valid
//   in_ready     out  1      S1 can accept this cycle
//   in_op        in   4      ALU control code
//   in_a         in   DW     operand A (rs)
//   in_b         in   DW     operand B (rt / immediate)
//   out_valid    out  1      result valid
//   out_ready    in   1      downstream accepts
//   out_result   out  DW     ALU result
//   out_zero     out  1      out_result == 0
//   out_taken    out  1      branch condition true (branch ops only)
//   out_ovf      out  1      signed overflow (add/sub only)
//   out_illegal  out  1      op code was 1100..1111
//   taken_cnt    out  CNT_W  taken-branch handshake count
// ---------------------------------------------------------------------------
module alu_exec_pipe #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_result,
  output logic             out_zero,
  output logic             out_taken,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [CNT_W-1:0] taken_cnt
);

  // ALU control codes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_BGEZ = 4'b1000;
  localparam logic [3:0] OP_BGTZ = 4'b1001;
  localparam logic [3:0] OP_BLEZ = 4'b1010;
  localparam logic [3:0] OP_BLTZ = 4'b1011;

  // -------------------------------------------------------------------------
  // Stage 1: operand registers
  // -------------------------------------------------------------------------
  logic          s1_valid;
  logic [3:0]    s1_op;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;

  logic          s2_valid;
  logic          s1_adv;
  logic          in_accept;

  // S1 moves into S2 when S2 is empty or is being drained on this edge.
  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  // S1 can take a new op when it is empty or is emptying on this edge.
  assign in_ready  = !s1_valid || s1_adv;
  assign in_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (in_accept) begin
        s1_valid <= 1'b1;
        s1_op    <= in_op;
        s1_a     <= in_a;
        s1_b     <= in_b;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Execute: combinational ALU on the S1 contents
  // -------------------------------------------------------------------------
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic          add_ovf;
  logic          sub_ovf;
  logic          lt_signed;
  logic          a_neg;
  logic          a_zero;

  logic [DW-1:0] ex_result;
  logic          ex_zero;
  logic          ex_taken;
  logic          ex_ovf;
  logic          ex_illegal;

  assign sum       = s1_a + s1_b;
  assign diff      = s1_a - s1_b;
  // Add overflows when both operands share a sign that the sum does not.
  assign add_ovf   = (s1_a[DW-1] == s1_b[DW-1]) && (sum[DW-1] != s1_a[DW-1]);
  // Sub overflows when operand signs differ and the result takes B's sign.
  assign sub_ovf   = (s1_a[DW-1] != s1_b[DW-1]) && (diff[DW-1] != s1_a[DW-1]);
  assign lt_signed = $signed(s1_a) < $signed(s1_b);
  assign a_neg     = s1_a[DW-1];
  assign a_zero    = (s1_a == '0);

  always_comb begin
    ex_result  = '0;
    ex_taken   = 1'b0;
    ex_ovf     = 1'b0;
    ex_illegal = 1'b0;
    case (s1_op)
      OP_ADD: begin
        ex_result = sum;
        ex_ovf    = add_ovf;
      end
      OP_SUB: begin
        ex_result = diff;
        ex_ovf    = sub_ovf;
      end
      OP_SLT:  ex_result = {{(DW-1){1'b0}}, lt_signed};
      OP_OR:   ex_result = s1_a | s1_b;
      OP_AND:  ex_result = s1_a & s1_b;
      OP_NOR:  ex_result = ~(s1_a | s1_b);
      // Branch ops report a-b as their result. Their flag is a compare only,
      // so ovf stays 0.
      OP_BEQ: begin
        ex_result = diff;
        ex_taken  = (s1_a == s1_b);
      end
      OP_BNE: begin
        ex_result = diff;
        ex_taken  = (s1_a != s1_b);
      end
      OP_BGEZ: begin
        ex_result = diff;
        ex_taken  = !a_neg;
      end
      OP_BGTZ: begin
        ex_result = diff;
        ex_taken  = !a_neg && !a_zero;
      end
      OP_BLEZ: begin
        ex_result = diff;
        ex_taken  = a_neg || a_zero;
      end
      OP_BLTZ: begin
        ex_result = diff;
        ex_taken  = a_neg;
      end
      default: begin
        // 1100..1111: flows down the pipe as a zero result with only the
        // illegal flag set.
        ex_illegal = 1'b1;
      end
    endcase
  end

  assign ex_zero = (ex_result == '0);

  // -------------------------------------------------------------------------
  // Stage 2: output registers
  // -------------------------------------------------------------------------
  logic [DW-1:0] s2_result;
  logic          s2_zero;
  logic          s2_taken;
  logic          s2_ovf;
  logic          s2_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_taken   <= 1'b0;
      s2_ovf     <= 1'b0;
      s2_illegal <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid   <= 1'b1;
        s2_result  <= ex_result;
        s2_zero    <= ex_zero;
        s2_taken   <= ex_taken;
        s2_ovf     <= ex_ovf;
        s2_illegal <= ex_illegal;
      end else if (out_ready) begin
        // The data fields keep their last value. Only valid drops.
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_zero    = s2_zero;
  assign out_taken   = s2_taken;
  assign out_ovf     = s2_ovf;
  assign out_illegal = s2_illegal;

  // -------------------------------------------------------------------------
  // Taken-branch counter
  // -------------------------------------------------------------------------
`ifdef ALU_TAKEN_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;

  // Counts only a completed output handshake. A taken op that is stalled in
  // S2 is not counted until it leaves.
  assign cnt_inc = s2_valid && out_ready && s2_taken && (cnt_q != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_exec_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_pipe
//
// Self-checking bench for alu_exec_pipe (DW=32, CNT_W=2 so that counter
// saturation is reachable). The bench is organised as follows:
//   - A reference model computes each op from its arithmetic definition,
//     using 64-bit signed integers.
//   - A scoreboard queue holds the expected outputs of the ops accepted into
//     the pipe. The head of the queue must be on out_* on every cycle in which
//     out_valid is high.
//   - Directed cases cover the specification's examples.
//   - A randomized phase follows the directed cases.
// ---------------------------------------------------------------------------
module tb_alu_exec_pipe;

  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int EW   = DW + 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_taken;
  logic          out_ovf;
  logic          out_illegal;
  logic [CW-1:0] taken_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {result, zero, taken, ovf, illegal} for each op in flight
  logic [EW-1:0] exp_q[$];
  int            exp_cnt = 0;

  alu_exec_pipe #(.DW(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_taken  (out_taken),
    .out_ovf    (out_ovf),
    .out_illegal(out_illegal),
    .taken_cnt  (taken_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_op(input logic [3:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    longint        sa, sb, r, maxv, minv;
    logic [DW-1:0] res;
    logic          t, v, ill;
    maxv = (longint'(1) <<< (DW-1)) - 1;
    minv = -(longint'(1) <<< (DW-1));
    sa   = $signed(a);
    sb   = $signed(b);
    res  = '0;
    t    = 1'b0;
    v    = 1'b0;
    ill  = 1'b0;
    r    = 0;
    case (op)
      4'd0: begin r = sa + sb; res = r[DW-1:0]; v = (r > maxv) || (r < minv); end
      4'd1: begin r = sa - sb; res = r[DW-1:0]; v = (r > maxv) || (r < minv); end
      4'd2: res = (sa < sb) ? DW'(1) : DW'(0);
      4'd3: res = a | b;
      4'd4: res = a & b;
      4'd5: res = ~(a | b);
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
        r   = sa - sb;
        res = r[DW-1:0];
        case (op)
          4'd6:    t = (sa == sb);
          4'd7:    t = (sa != sb);
          4'd8:    t = (sa >= 0);
          4'd9:    t = (sa > 0);
          4'd10:   t = (sa <= 0);
          default: t = (sa < 0);
        endcase
      end
      default: ill = 1'b1;
    endcase
    return {res, (res == '0), t, v, ill};
  endfunction

  function automatic int cnt_exp(input int n);
`ifdef ALU_TAKEN_CNT_EN
    return (n > CMAX) ? CMAX : n;
`else
    return 0;
`endif
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Runs at negedge. It samples the signals that decide the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_cnt = 0;
      end else begin
        check("taken_cnt", 64'(taken_cnt), 64'(exp_cnt));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("out_unexpected", 64'(1), 64'(0));
          end else begin
            check("out_fields",
                  64'({out_result, out_zero, out_taken, out_ovf, out_illegal}),
                  64'(exp_q[0]));
            if (out_ready) begin
`ifdef ALU_TAKEN_CNT_EN
              if (exp_q[0][2] && exp_cnt < CMAX) exp_cnt++;
`endif
              void'(exp_q.pop_front());
            end
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model_op(in_op, in_a, in_b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1. Returns at posedge+1 after the edge that accepted the op.
  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic acc;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    acc      = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one op into an empty pipe with out_ready=1. Checks the latency and
  // compares the outputs against fixed constants.
  task automatic expect_one(input string tag, input logic [3:0] op,
                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] e_res, input logic e_zero,
                            input logic e_taken, input logic e_ovf, input logic e_ill);
    out_ready = 1'b1;
    send(op, a, b);
    check({tag, "_lat_n"}, 64'(out_valid), 64'(0));
    idle(1);
    check({tag, "_lat_n1"}, 64'(out_valid), 64'(1));
    check({tag, "_result"}, 64'(out_result), 64'(e_res));
    check({tag, "_flags"}, 64'({out_zero, out_taken, out_ovf, out_illegal}),
          64'({e_zero, e_taken, e_ovf, e_ill}));
    idle(1);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return DW'(1);
      2:       return '1;
      3:       return {1'b0, {(DW-1){1'b1}}};
      4:       return {1'b1, {(DW-1){1'b0}}};
      default: return DW'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic          acc;
    int            acc_n;
    int            idx;
    logic [DW-1:0] ra;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_taken_cnt", 64'(taken_cnt), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'(1));
    idle(1);

    // Arithmetic and overflow
    expect_one("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 0);
    expect_one("sub_ovf", 4'b0001, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 0, 1, 0);

    // Back-to-back sub then slt
    out_ready = 1'b1;
    send(4'b0001, 32'd5, 32'd5);
    check("b2b_lat", 64'(out_valid), 64'(0));
    send(4'b0010, 32'hFFFF_FFFF, 32'd1);
    check("b2b_first_v", 64'(out_valid), 64'(1));
    check("b2b_first", 64'({out_result, out_zero}), 64'({32'd0, 1'b1}));
    idle(1);
    check("b2b_second_v", 64'(out_valid), 64'(1));
    check("b2b_second", 64'({out_result, out_zero}), 64'({32'd1, 1'b0}));
    idle(1);
    check("b2b_empty", 64'(out_valid), 64'(0));

    // Branch tests and one non-branch op
    expect_one("beq", 4'b0110, 32'h1234, 32'h1234, 32'h0, 1, 1, 0, 0);
    expect_one("bltz", 4'b1011, 32'h8000_0000, 32'h0, 32'h8000_0000, 0, 1, 0, 0);
    expect_one("bgtz", 4'b1001, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
    expect_one("or", 4'b0011, 32'h1234, 32'h4321, 32'h5335, 0, 0, 0, 0);
    expect_one("illegal", 4'b1110, 32'h5, 32'h7, 32'h0, 1, 0, 0, 1);

    // Stall: out_ready=0 for 4 cycles with 3 ops offered
    out_ready = 1'b0;
    acc_n     = 0;
    idx       = 0;
    in_valid  = 1'b1;
    in_op     = 4'b0000;
    in_b      = 32'd1;
    in_a      = 32'd10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_n++;
        idx++;
      end
      @(posedge clk);
      #1;
      in_a = 32'(10 * (idx + 1));
    end
    check("stall_accepts", 64'(acc_n), 64'(2));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    check("stall_head", 64'({out_valid, out_result}), 64'({1'b1, 32'd11}));
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    idle(4);
    check("stall_drain", 64'(exp_q.size()), 64'(0));

    // Reset while the pipe is full
    out_ready = 1'b0;
    send(4'b0111, 32'd1, 32'd2);
    send(4'b0111, 32'd3, 32'd4);
    idle(1);
    check("full_in_ready", 64'(in_ready), 64'(0));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out", 64'({out_result, out_taken}), 64'(0));
    check("midrst_taken_cnt", 64'(taken_cnt), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("midrst_in_ready", 64'(in_ready), 64'(1));
    idle(1);
    check("midrst_empty", 64'(out_valid), 64'(0));

    // Counter: a stalled taken op is not counted until it is accepted
    out_ready = 1'b0;
    send(4'b0111, 32'd7, 32'd8);
    idle(3);
    check("cnt_stalled", 64'(taken_cnt), 64'(0));
    out_ready = 1'b1;
    idle(1);
    check("cnt_one", 64'(taken_cnt), 64'(cnt_exp(1)));
    for (int i = 0; i < 4; i++) send(4'b0111, 32'(i), 32'(i + 100));
    idle(3);
    check("cnt_sat", 64'(taken_cnt), 64'(cnt_exp(5)));

    // Randomized traffic
    in_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_op    = 4'($urandom_range(0, 15));
        ra       = pick();
        in_a     = ra;
        in_b     = ($urandom_range(0, 3) == 0) ? ra : pick();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("rand_drain", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
